// File: rtl/popcount_engine.sv
// Popcount engine: reads words from memory, counts ones/zeros/parity CHUNK
// bits per cycle, writes each per-word result back and accumulates a total.
module popcount_engine #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CHUNK  = 8,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned LEN_W = ADDR_W + 1,
    localparam int unsigned CW    = $clog2(WIDTH + 1),
    localparam int unsigned TOT_W = LEN_W + CW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [TOT_W-1:0]  total
);

    // WIDTH is expected to be an integer multiple of CHUNK.
    localparam int unsigned N   = WIDTH / CHUNK;
    localparam int unsigned NCW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_COUNT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic              mode_zeros;
    logic              mode_par;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [WIDTH-1:0]  shreg;
    logic [CW-1:0]     acc;
    logic [NCW-1:0]    ccnt;

    logic [CW-1:0]     chunk_ones;
    logic [CW-1:0]     chunk_add;
    logic [CW-1:0]     acc_next;
    logic [CW-1:0]     word_result;
    logic [LEN_W-1:0]  idx_next;
    logic              last_chunk;

    // Number of set bits in one chunk.
    function automatic logic [CW-1:0] popc(input logic [CHUNK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Per-cycle chunk arithmetic and word bookkeeping.
    always_comb begin
        chunk_ones  = popc(shreg[CHUNK-1:0]);
        chunk_add   = mode_zeros ? (CW'(CHUNK) - chunk_ones) : chunk_ones;
        acc_next    = acc + chunk_add;
        word_result = mode_par ? CW'(acc_next[0]) : acc_next;
        idx_next    = idx + LEN_W'(1);
        last_chunk  = (ccnt == NCW'(N - 1));
    end

    // Job sequencer with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            mode_zeros <= 1'b0;
            mode_par   <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            shreg      <= '0;
            acc        <= '0;
            ccnt       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            total      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_zeros <= (mode == 2'b01);
                        mode_par   <= (mode == 2'b10);
                        src_q      <= src_base;
                        dst_q      <= dst_base;
                        len_q      <= length;
                        idx        <= '0;
                        total      <= '0;
                        busy       <= 1'b1;
                        if (length == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_READ;
                            rd_en   <= 1'b1;
                            rd_addr <= src_base;
                        end
                    end
                end
                S_READ: begin
                    rd_en <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    shreg <= rd_data;
                    acc   <= '0;
                    ccnt  <= '0;
                    state <= S_COUNT;
                end
                S_COUNT: begin
                    acc   <= acc_next;
                    shreg <= shreg >> CHUNK;
                    ccnt  <= ccnt + NCW'(1);
                    if (last_chunk) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dst_q + idx[ADDR_W-1:0];
                        wr_data <= WIDTH'(word_result);
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_en <= 1'b0;
                    total <= total + TOT_W'(wr_data[CW-1:0]);
                    idx   <= idx_next;
                    if (idx_next == len_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_READ;
                        rd_en   <= 1'b1;
                        rd_addr <= src_q + idx_next[ADDR_W-1:0];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_engine.sv
// Directed bench for popcount_engine with a behavioural single-port memory.
module tb_popcount_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  src_base;
    logic [7:0]  dst_base;
    logic [8:0]  length;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [14:0] total;

    logic [31:0] mem [256];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic [7:0]  rd_log[$];
    logic [7:0]  wr_log[$];
    int          cyc;
    int          k;
    int          overlap;
    int          done_cnt;
    int          n_total;
    int          n_bad;

    popcount_engine #(.WIDTH(32), .CHUNK(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .total(total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model, cycle counter and port monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_log.push_back(rd_addr);
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            wr_log.push_back(wr_addr);
        end
        if (ld_en) mem[ld_addr] <= ld_data;
        if (rd_en && wr_en) overlap <= overlap + 1;
    end

    // Count done pulses seen mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic start_job(input logic [1:0] m, input logic [7:0] s, input logic [7:0] d,
                             input logic [8:0] l);
        @(negedge clk);
        mode = m; src_base = s; dst_base = d; length = l; start = 1'b1;
        rd_log.delete(); wr_log.delete(); done_cnt = 0;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_delta);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, done ? 64'(cyc - k) : 64'hFFFF_FFFF, 64'(exp_delta));
        @(negedge clk);
        check({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic check_results(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] r3, input logic [14:0] t);
        check({tag, "_m40"}, 64'(mem[40]), 64'(r0));
        check({tag, "_m41"}, 64'(mem[41]), 64'(r1));
        check({tag, "_m42"}, 64'(mem[42]), 64'(r2));
        check({tag, "_m43"}, 64'(mem[43]), 64'(r3));
        check({tag, "_total"}, 64'(total), 64'(t));
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0; overlap = 0; done_cnt = 0; k = 0;
        reset = 1'b0; start = 1'b0; mode = 2'b00; src_base = '0; dst_base = '0;
        length = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_total", 64'(total), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        reset = 1'b1;

        poke(8'd20, 32'hFFFF_FFFF);
        poke(8'd21, 32'h0000_0000);
        poke(8'd22, 32'h8000_0001);
        poke(8'd23, 32'h1234_5678);

        // Count ones
        start_job(2'b00, 8'd20, 8'd40, 9'd4);
        check("m00_busy", 64'(busy), 64'd1);
        wait_done("m00_done_time", 28);
        check_results("m00", 32'd32, 32'd0, 32'd2, 32'd13, 15'd47);
        check("m00_reads", 64'(rd_log.size()), 64'd4);
        check("m00_writes", 64'(wr_log.size()), 64'd4);
        check("m00_done_cnt", 64'(done_cnt), 64'd1);

        // Count zeros
        start_job(2'b01, 8'd20, 8'd40, 9'd4);
        wait_done("m01_done_time", 28);
        check_results("m01", 32'd0, 32'd32, 32'd30, 32'd19, 15'd81);

        // Parity of ones
        start_job(2'b10, 8'd20, 8'd40, 9'd4);
        wait_done("m10_done_time", 28);
        check_results("m10", 32'd0, 32'd0, 32'd0, 32'd1, 15'd1);

        // Reserved mode behaves as count ones
        start_job(2'b11, 8'd20, 8'd40, 9'd4);
        wait_done("m11_done_time", 28);
        check_results("m11", 32'd32, 32'd0, 32'd2, 32'd13, 15'd47);

        // Zero-length job
        start_job(2'b00, 8'd20, 8'd40, 9'd0);
        wait_done("len0_done_time", 0);
        check("len0_reads", 64'(rd_log.size()), 64'd0);
        check("len0_writes", 64'(wr_log.size()), 64'd0);
        check("len0_total", 64'(total), 64'd0);

        // Address wrap-around
        poke(8'd255, 32'h0000_000F);
        poke(8'd0, 32'h0000_00FF);
        start_job(2'b00, 8'd255, 8'd254, 9'd2);
        wait_done("wrap_done_time", 14);
        check("wrap_nrd", 64'(rd_log.size()), 64'd2);
        check("wrap_nwr", 64'(wr_log.size()), 64'd2);
        if (rd_log.size() == 2 && wr_log.size() == 2) begin
            check("wrap_rd0", 64'(rd_log[0]), 64'd255);
            check("wrap_rd1", 64'(rd_log[1]), 64'd0);
            check("wrap_wr0", 64'(wr_log[0]), 64'd254);
            check("wrap_wr1", 64'(wr_log[1]), 64'd255);
        end
        check("wrap_m254", 64'(mem[254]), 64'd4);
        check("wrap_m255", 64'(mem[255]), 64'd8);
        check("wrap_total", 64'(total), 64'd12);

        // Reset during COUNT of word 2
        for (int i = 40; i < 44; i++) poke(8'(i), 32'hDEAD_BEEF);
        start_job(2'b00, 8'd20, 8'd40, 9'd4);
        while (cyc < k + 17) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_rd_en", 64'(rd_en), 64'd0);
        check("mrst_wr_en", 64'(wr_en), 64'd0);
        check("mrst_total", 64'(total), 64'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("mrst_idle", 64'(busy), 64'd0);
        check("mrst_no_done", 64'(done_cnt), 64'd0);
        check("mrst_nwr", 64'(wr_log.size()), 64'd2);
        check_results("mrst", 32'd32, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 15'd0);
        start_job(2'b00, 8'd20, 8'd40, 9'd4);
        wait_done("mrst_fresh_time", 28);
        check_results("mrst_fresh", 32'd32, 32'd0, 32'd2, 32'd13, 15'd47);

        // Start pulses while busy are ignored
        for (int i = 40; i < 44; i++) poke(8'(i), 32'hDEAD_BEEF);
        start_job(2'b00, 8'd20, 8'd40, 9'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; mode = 2'b01; src_base = 8'd0; dst_base = 8'd41; length = 9'd1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("busy_done_time", 28);
        check_results("busy", 32'd32, 32'd0, 32'd2, 32'd13, 15'd47);
        check("busy_nwr", 64'(wr_log.size()), 64'd4);

        check("rd_wr_overlap", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
